// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream valid/ready in, downstream valid/ready out.
// The slave modport is the register's view; master is the surrounding stages' view.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 272
);
  logic [WIDTH-1:0] In_Data;
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] Out_Data;
  logic             Out_Valid;
  logic             Out_Ready;
  logic             Flush;
  logic [1:0]       Count;

  modport slave (
    input  In_Data, In_Valid, Out_Ready, Flush,
    output In_Ready, Out_Data, Out_Valid, Count
  );

  modport master (
    output In_Data, In_Valid, Out_Ready, Flush,
    input  In_Ready, Out_Data, Out_Valid, Count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and an
// optional two-entry skid buffer that makes In_Ready a registered signal.
module pipe_stage_reg #(
  parameter int               WIDTH  = 272,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter bit               SKID   = 1'b1
) (
  input logic              Clk,
  input logic              Rst,
  pipe_stage_reg_if.slave  bus
);

  // Occupancy doubles as the FSM state, so Count is a direct view of it.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_ready_s;
  logic             accept_s;
  logic             release_s;

  // Handshake qualification; without the skid slot, readiness must see Out_Ready.
  always_comb begin
    if (SKID) begin
      in_ready_s = in_ready_q;
    end else begin
      in_ready_s = !out_valid_q || bus.Out_Ready;
    end
    accept_s  = bus.In_Valid && in_ready_s;
    release_s = out_valid_q && bus.Out_Ready;
  end

  // Next-state and datapath; main is parked at BUBBLE whenever nothing valid is held.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          main_d  = bus.In_Data;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && release_s) begin
          main_d = bus.In_Data;
        end else if (accept_s && SKID) begin
          skid_d  = bus.In_Data;
          state_d = ST_TWO;
        end else if (release_s) begin
          main_d  = BUBBLE;
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (release_s) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        main_d  = BUBBLE;
        state_d = ST_EMPTY;
      end
    endcase

    if (bus.Flush) begin
      main_d  = BUBBLE;
      state_d = ST_EMPTY;
    end else begin
      main_d  = main_d;
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // State and data registers with synchronous reset to the bubble state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.Out_Data  = main_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Count     = state_q;
  assign bus.In_Ready  = in_ready_s;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share one stimulus stream and are
// compared every cycle against a queue model, plus directed literal checks.
module tb_pipe_stage_reg;

  localparam logic [7:0] BUB = 8'hA5;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       flush;

  int n_checks;
  int n_fail;

  pipe_stage_reg_if #(.WIDTH(8)) if1 ();
  pipe_stage_reg_if #(.WIDTH(8)) if0 ();

  assign if1.In_Data   = in_data;
  assign if1.In_Valid  = in_valid;
  assign if1.Out_Ready = out_ready;
  assign if1.Flush     = flush;
  assign if0.In_Data   = in_data;
  assign if0.In_Valid  = in_valid;
  assign if0.Out_Ready = out_ready;
  assign if0.Flush     = flush;

  pipe_stage_reg #(.WIDTH(8), .BUBBLE(BUB), .SKID(1'b1)) dut_skid (
    .Clk (clk),
    .Rst (rst),
    .bus (if1)
  );

  pipe_stage_reg #(.WIDTH(8), .BUBBLE(BUB), .SKID(1'b0)) dut_noskid (
    .Clk (clk),
    .Rst (rst),
    .bus (if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a FIFO of held words; capacity 2 with skid, 1 without.
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  always @(posedge clk) begin
    bit rdy1, rdy0;
    rdy1 = (q1.size() < 2);
    rdy0 = (q0.size() == 0) || out_ready;
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (in_valid && rdy1) q1.push_back(in_data);
      if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      if (in_valid && rdy0) q0.push_back(in_data);
      if (flush) begin
        q1.delete();
        q0.delete();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("skid_valid", {31'd0, if1.Out_Valid}, {31'd0, q1.size() > 0});
    chk("skid_data",  {24'd0, if1.Out_Data}, {24'd0, (q1.size() > 0) ? q1[0] : BUB});
    chk("skid_count", {30'd0, if1.Count}, q1.size());
    chk("skid_ready", {31'd0, if1.In_Ready}, {31'd0, q1.size() < 2});
    chk("noskid_valid", {31'd0, if0.Out_Valid}, {31'd0, q0.size() > 0});
    chk("noskid_data",  {24'd0, if0.Out_Data}, {24'd0, (q0.size() > 0) ? q0[0] : BUB});
    chk("noskid_count", {30'd0, if0.Count}, q0.size());
    chk("noskid_ready", {31'd0, if0.In_Ready}, {31'd0, (q0.size() == 0) || out_ready});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] data, input logic valid,
                     input logic [1:0] count, input logic rdy);
    chk({name, "_data"},  {24'd0, if1.Out_Data}, {24'd0, data});
    chk({name, "_valid"}, {31'd0, if1.Out_Valid}, {31'd0, valid});
    chk({name, "_count"}, {30'd0, if1.Count}, {30'd0, count});
    chk({name, "_ready"}, {31'd0, if1.In_Ready}, {31'd0, rdy});
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    out_ready = 1'b0;
    flush     = 1'b0;
    tick();
    tick();
    lit("reset", BUB, 1'b0, 2'd0, 1'b1);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Streaming with Out_Ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data = 8'h01; tick(); lit("stream1", 8'h01, 1'b1, 2'd1, 1'b1);
    in_data = 8'h02; tick(); lit("stream2", 8'h02, 1'b1, 2'd1, 1'b1);
    in_data = 8'h03; tick(); lit("stream3", 8'h03, 1'b1, 2'd1, 1'b1);
    in_valid = 1'b0; tick(); lit("stream_end", BUB, 1'b0, 2'd0, 1'b1);

    // Stall fills the skid slot; third word must wait
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'h10; tick(); lit("stall1", 8'h10, 1'b1, 2'd1, 1'b1);
    in_data = 8'h20; tick(); lit("stall2", 8'h10, 1'b1, 2'd2, 1'b0);
    in_data = 8'h30; tick(); lit("stall3", 8'h10, 1'b1, 2'd2, 1'b0);
    out_ready = 1'b1;
    tick(); lit("drain20", 8'h20, 1'b1, 2'd1, 1'b1);
    tick(); lit("drain30", 8'h30, 1'b1, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick(); lit("drain_end", BUB, 1'b0, 2'd0, 1'b1);

    // Flush while full, with a word offered in the flush cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'h10; tick();
    in_data = 8'h20; tick(); lit("preflush", 8'h10, 1'b1, 2'd2, 1'b0);
    in_data = 8'h40; flush = 1'b1; out_ready = 1'b1;
    tick(); lit("flush", BUB, 1'b0, 2'd0, 1'b1);
    flush = 1'b0; in_valid = 1'b0;
    tick(); lit("postflush", BUB, 1'b0, 2'd0, 1'b1);

    // Simultaneous accept and release at Count=1
    in_valid = 1'b1;
    in_data = 8'h54; tick(); lit("simul1", 8'h54, 1'b1, 2'd1, 1'b1);
    in_data = 8'h55; tick(); lit("simul2", 8'h55, 1'b1, 2'd1, 1'b1);
    in_valid = 1'b0; tick();

    // Reset mid-stall wins over everything
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'h66; tick();
    in_data = 8'h77; tick();
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick(); lit("rst_stall", BUB, 1'b0, 2'd0, 1'b1);
    rst = 1'b0; flush = 1'b0;

    // Combinational readiness and one-edge replacement without the skid slot
    out_ready = 1'b0;
    in_data = 8'hA1; tick();
    chk("noskid_hold_ready", {31'd0, if0.In_Ready}, 32'd0);
    chk("noskid_hold_data", {24'd0, if0.Out_Data}, 32'h0000_00A1);
    in_data = 8'hB2; tick();
    chk("noskid_blocked_data", {24'd0, if0.Out_Data}, 32'h0000_00A1);
    out_ready = 1'b1;
    #1;
    chk("noskid_comb_ready", {31'd0, if0.In_Ready}, 32'd1);
    tick();
    chk("noskid_replace_data", {24'd0, if0.Out_Data}, 32'h0000_00B2);
    chk("noskid_replace_count", {30'd0, if0.Count}, 32'd1);
    in_valid = 1'b0;
    tick();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, successor to the fixed-width ID/EX latch.
Carries a WIDTH-bit stage bundle between pipeline stages using a valid/ready handshake.
Supports back-pressure (stall), a synchronous flush that inserts a bubble, and an optional 2-entry skid buffer so that In_Ready is registered.
One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
WIDTH, 272, bit width of the stage bundle.
BUBBLE, {WIDTH{1'b0}}, value driven on Out_Data whenever Out_Valid=0 (reset, empty, after flush).
SKID, 1, 1 = two-entry skid buffer with registered In_Ready; 0 = single register with combinational In_Ready.

Ports:
Clk  input  1  rising-edge clock.
Rst  input  1  reset, synchronous, active-high.
In_Data  input  WIDTH  bundle from the upstream stage.
In_Valid  input  1  upstream word valid.
In_Ready  output  1  block can accept a word this cycle.
Out_Data  output  WIDTH  bundle to the downstream stage.
Out_Valid  output  1  Out_Data holds a valid word.
Out_Ready  input  1  downstream accepts this cycle (0 = stall).
Flush  input  1  discard all held words; next cycle is a bubble.
Count  output  2  number of words held (0..2; max 1 when SKID=0).

Behaviour:
- Accept: In_Valid && In_Ready at a rising edge. Release: Out_Valid && Out_Ready at a rising edge.
- Reset (Rst=1 at an edge): Count=0, Out_Valid=0, Out_Data=BUBBLE, In_Ready=1. Rst has priority over Flush and all transfers, including mid-stall.
- Latency: a word accepted at edge N appears on Out_Data/Out_Valid after edge N, provided the main register is empty or releasing at edge N.
- Out_Data is registered. It is forced to BUBBLE whenever Out_Valid=0, never stale data.
- Stability: while Out_Valid=1 and Out_Ready=0, Out_Data and Out_Valid hold unchanged.
- Order is strictly FIFO. No word is duplicated or lost except by Flush or Rst.
- SKID=1 state machine (state = Count):
  - EMPTY(0): accept -> ONE; otherwise stay.
  - ONE(1): accept with no release -> TWO (word goes to the skid register); accept with release -> ONE (new word goes to main); release only -> EMPTY; neither -> stay.
  - TWO(2): In_Ready=0, so no accept. Release -> ONE, and the skid word moves to main at that same edge. No release -> stay.
  - In_Ready = (Count != 2), taken from a registered state bit with no combinational path from Out_Ready.
- SKID=0: In_Ready = !Out_Valid || Out_Ready (combinational). Simultaneous accept and release replaces main. Count is never 2.
- Flush=1 at an edge (Rst=0):
  - After the edge: Count=0, Out_Valid=0, Out_Data=BUBBLE, In_Ready=1.
  - A word accepted in the flush cycle counts as handshaken but is discarded.
  - A release in the flush cycle still counts as delivered.
- Flush, Rst and stall never produce X on Out_Data. The skid register content is don't-care when it is unoccupied.

Test Plan:
- Reset/bubble (WIDTH=8, BUBBLE=8'hA5): hold Rst 2 cycles with In_Valid=1, In_Data=8'h11 -> Out_Valid=0, Out_Data=8'hA5, Count=0, In_Ready=1.
- Streaming (SKID=1): Out_Ready=1, send 8'h01,02,03 on consecutive cycles -> Out_Data shows 01,02,03 one cycle later each with Out_Valid=1. Count never exceeds 1.
- Stall/skid fill: Out_Ready=0, send 8'h10 then 8'h20 -> Count=2, In_Ready=0, Out_Data holds 10. A third word 8'h30 offered is not accepted. Raise Out_Ready -> outputs 10, 20, then 30 accepted and output; nothing lost.
- Flush mid-stall: Count=2 (10, 20), assert Flush with In_Valid=1, In_Data=8'h40 -> next cycle Out_Valid=0, Out_Data=8'hA5, Count=0, In_Ready=1. 40 is never output.
- Simultaneous accept/release at Count=1: Out_Ready=1, In_Valid=1, In_Data=8'h55 -> Count stays 1, Out_Data=55 next cycle.
- SKID=0 variant: Out_Ready=0 with Out_Valid=1 -> In_Ready=0 in the same cycle. Out_Ready=1 -> In_Ready=1 combinationally, and the word is replaced in one edge.
